// File: rtl/neuron_argmax.sv
// rtl/neuron_argmax.sv - streaming argmax over one frame of neuron scores
// Reports winning class index, its score and the margin over the runner-up.
module neuron_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [3:0]        digit,
    output logic [DATA_W-1:0] max_score,
    output logic [DATA_W:0]   margin,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);
    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    state_t                    state;
    logic [3:0]                count;
    logic [3:0]                best_idx;
    logic signed [DATA_W-1:0]  best;
    logic signed [DATA_W-1:0]  second;

    logic                      accept;
    logic signed [DATA_W-1:0]  score;
    logic signed [DATA_W-1:0]  nxt_best;
    logic signed [DATA_W-1:0]  nxt_second;
    logic [3:0]                nxt_idx;
    logic [DATA_W:0]           nxt_margin;

    assign in_ready = (state != DONE);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;
    assign score    = $signed(in_data);

    // Strictly-greater replacement keeps the lower index on ties.
    always_comb begin
        nxt_best   = best;
        nxt_second = second;
        nxt_idx    = best_idx;
        if (state == IDLE) begin
            nxt_best   = score;
            nxt_second = MOST_NEG;
            nxt_idx    = 4'd0;
        end else if (score > best) begin
            nxt_best   = score;
            nxt_second = best;
            nxt_idx    = count;
        end else if (score > second) begin
            nxt_second = score;
        end
        nxt_margin = {nxt_best[DATA_W-1], nxt_best} - {nxt_second[DATA_W-1], nxt_second};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= 4'd0;
            best      <= '0;
            second    <= '0;
            best_idx  <= 4'd0;
            out_valid <= 1'b0;
            digit     <= 4'd0;
            max_score <= '0;
            margin    <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && !clear) begin
                        best     <= nxt_best;
                        second   <= nxt_second;
                        best_idx <= nxt_idx;
                        count    <= 4'd1;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (clear) begin
                        count <= 4'd0;
                        state <= IDLE;
                    end else if (accept) begin
                        best     <= nxt_best;
                        second   <= nxt_second;
                        best_idx <= nxt_idx;
                        if (count == LAST_IDX) begin
                            // Result registered here so it is visible during DONE.
                            count     <= 4'd0;
                            state     <= DONE;
                            out_valid <= 1'b1;
                            digit     <= nxt_idx;
                            max_score <= nxt_best;
                            margin    <= nxt_margin;
                        end else begin
                            count <= count + 4'd1;
                        end
                    end
                end
                DONE: begin
                    count <= 4'd0;
                    state <= IDLE;
                end
                default: begin
                    count <= 4'd0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/neuron_argmax.md
NEURON_ARGMAX -- requirements
Module: neuron_argmax

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 10, number of neuron scores per frame (2..16).
REQ-002 SHALL have parameter DATA_W, default 26, score width matching the neuron output width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port clear, input, 1, synchronous abort of the current frame.
REQ-006 SHALL have port in_valid, input, 1, a neuron score is presented this cycle.
REQ-007 SHALL have port in_data, input, DATA_W, neuron score in two's-complement fixed point.
REQ-008 SHALL have port in_ready, output, 1, block accepts in_data this cycle.
REQ-009 SHALL have port out_valid, output, 1, one-cycle pulse marking a classification result.
REQ-010 SHALL have port digit, output, 4, index of the winning class.
REQ-011 SHALL have port max_score, output, DATA_W, winning score.
REQ-012 SHALL have port margin, output, DATA_W+1, unsigned difference between winner and runner-up.
REQ-013 SHALL have port busy, output, 1, a frame is partially received.

Function
REQ-014 SHALL accept a score only on a cycle with in_valid=1 and in_ready=1 (accept); scores arrive in class order 0..NUM_CLASSES-1.
REQ-015 SHALL implement states IDLE, ACCUM and DONE.
REQ-016 In IDLE, an accept SHALL load best=in_data, best_idx=0, second=most-negative DATA_W value, count=1, and move to ACCUM.
REQ-017 In ACCUM, each accept SHALL compare signed values and update state as follows:
- if in_data > best: second=best, best=in_data, best_idx=count;
- else if in_data > second: second=in_data;
- in all cases, count increments.
REQ-018 Ties SHALL keep the lower index, so replacement happens only on strictly greater.
REQ-019 The accept with count=NUM_CLASSES-1 SHALL move the block to DONE on the next edge.
REQ-020 In DONE, for exactly one cycle, the block SHALL drive:
- out_valid=1;
- digit=best_idx;
- max_score=best;
- margin=best-second, computed at DATA_W+1 bits and never negative.
The block then returns to IDLE.
REQ-021 Latency SHALL be one cycle: out_valid is high in the cycle after the final accept.
REQ-022 in_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE; an in_valid during DONE is dropped and does not start a frame.
REQ-023 Outside DONE, out_valid SHALL be 0; digit, max_score and margin SHALL hold the last result until the next DONE.
REQ-024 busy SHALL be 1 in ACCUM and DONE, and 0 in IDLE.
REQ-025 in_valid=0 in ACCUM SHALL stall with state unchanged; there is no timeout.
REQ-026 clear=1 SHALL return the block to IDLE with count=0, discard the partial frame, and suppress the next out_valid; result outputs are held.
REQ-027 If clear and an accept coincide, clear SHALL win and the score is discarded.
REQ-028 clear in DONE SHALL still allow the current out_valid pulse; the block then goes to IDLE.
REQ-029 With NUM_CLASSES-1 scores equal to the most-negative value, margin SHALL be 0 when the remaining score equals them.

Reset
REQ-030 rst=0 at a rising edge SHALL set the block as follows:
- state=IDLE, count=0;
- out_valid=0, digit=0, max_score=0, margin=0;
- busy=0, in_ready=1.
REQ-031 rst=0 mid-frame SHALL discard the frame with no out_valid; rst SHALL take priority over clear and accepts.

Verification
REQ-032 Back-to-back valid scores 5,-3,100,7,100,0,2,1,-8,99 -> one cycle after the 10th accept: out_valid=1, digit=2, max_score=100, margin=0, and in_ready=0 in that cycle.
REQ-033 Scores 0..9 (value=index) with in_valid gaps of 3 cycles -> digit=9, max_score=9, margin=1, busy=1 from the first accept until out_valid.
REQ-034 Four scores sent, clear pulsed, then ten scores all -2 -> exactly one out_valid: digit=0, max_score=-2 (two's complement), margin=0.
REQ-035 in_valid held high through DONE with score 50 -> that score is not accepted; the next frame's first accept is the cycle after DONE.
REQ-036 rst low after six accepts, then a full frame with scores 9..0 -> no out_valid during reset; the following result is digit=0, max_score=9, margin=1.
REQ-037 Scores of the most-negative value (0x2000000) for classes 0..8, and the most-positive value (0x1FFFFFF) for class 9 -> digit=9, margin=0x3FFFFFF.
